// File: rtl/queue_ctrl_pkg.sv
// queue_ctrl_pkg
// Shared types and constants for the queue write-arbiter / read-sequencer.
//   rd_state_t : read-side FSM states (IDLE, FETCH, HOLD)
//   CNT_W      : width of each per-requester accept counter
//   CNT_MAX    : saturation value of the accept counters
//   DEF_*      : default parameter values for queue_ctrl
package queue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rd_state_t;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEPTH   = 8;

endpackage

// File: rtl/queue_ctrl_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The search for a winner starts one past the last
// accepted requester, so every active requester is served within N grants.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector
//   en       : grant enable (no grant at all when low)
//   accept   : the current grant was taken; advances last_grant
//   gnt      : one-hot (or zero) grant
//   gnt_id   : encoded index of gnt (0 when no grant)
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic            accept,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            found;
  int              idx;

  // Walk the requesters in priority order last_grant+1 .. last_grant+N.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_q) + k) % N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = gnt_id;
  end

  // Starting at N-1 makes requester 0 the first winner after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= ID_W'(N - 1);
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/queue_ctrl.sv
// queue_ctrl
// Shares the write port of an 8-entry queue between NUM_REQ producers
// (valid/ready, round-robin) and turns the queue read port into a
// valid/ready stream for one consumer.
//   req_valid/req_data/req_ready : producer handshakes (req_ready one-hot)
//   q_we/q_in_data               : registered queue write port
//   q_free_entries               : free slots reported by the queue
//   q_re/q_out_data/q_empty      : queue read port (data one cycle after q_re)
//   out_valid/out_data/out_ready : consumer stream
//   grant_id                     : index of the last accepted requester
//   accept_cnt                   : per-requester saturating accept counts
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int FE_W    = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      q_we,
  output logic [DATA_W-1:0]         q_in_data,
  input  logic [FE_W-1:0]           q_free_entries,
  output logic                      q_re,
  input  logic [DATA_W-1:0]         q_out_data,
  input  logic                      q_empty,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic [NUM_REQ*CNT_W-1:0]  accept_cnt
);

  // ---------------- write side ----------------
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    arb_id;
  logic               credit_ok;
  logic               accept;
  logic [DATA_W-1:0]  req_data_arr [NUM_REQ];

  logic              q_we_q, q_we_d;
  logic [DATA_W-1:0] q_in_data_q, q_in_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  // A write issued last cycle has not yet shown up in q_free_entries, so it
  // is subtracted here; otherwise the queue could be written while full.
  // Ready is forced low during reset so all outputs read zero.
  assign credit_ok = (q_free_entries > FE_W'(q_we_q)) && !rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (credit_ok),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (arb_id)
  );

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  assign accept    = |gnt;
  assign req_ready = gnt;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    q_we_d      = accept;
    q_in_data_d = q_in_data_q;
    grant_id_d  = grant_id_q;
    if (accept) begin
      q_in_data_d = req_data_arr[arb_id];
      grant_id_d  = arb_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_we_q      <= 1'b0;
      q_in_data_q <= '0;
      grant_id_q  <= '0;
    end else begin
      q_we_q      <= q_we_d;
      q_in_data_q <= q_in_data_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign q_we      = q_we_q;
  assign q_in_data = q_in_data_q;
  assign grant_id  = grant_id_q;

  // Per-requester saturating accept counters.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (gnt[gi] && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign accept_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end

  // ---------------- read side ----------------
  rd_state_t         state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    q_re        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_re    = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Queue read data is valid exactly this cycle.
        out_data_d  = q_out_data;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!q_empty) begin
            q_re    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) q_re = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/queue_ctrl.md
# queue_ctrl

Write-arbiter and read-sequencer for the team's 8-entry `queue` FIFO. It shares the queue's single write port between `NUM_REQ` producers using valid/ready handshakes and round-robin fairness. It also converts the queue's `re`/`out_data` read port into a valid/ready stream for a single consumer. The block sits directly in front of and behind one `queue` instance and is the only agent driving its `we`, `in_data` and `re`.

## Interface
- `NUM_REQ`, 4: number of write requesters (2..8).
- `DATA_W`, 8: data width; matches the queue.
- `DEPTH`, 8: queue depth; sets the width of `q_free_entries`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_data`  in  NUM_REQ*DATA_W  requester i's data in bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-hot or zero; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `q_we`  out  1  registered queue write enable.
- `q_in_data`  out  DATA_W  registered queue write data.
- `q_free_entries`  in  $clog2(DEPTH)+1  free slots reported by the queue.
- `q_re`  out  1  queue read enable.
- `q_out_data`  in  DATA_W  queue read data, valid the cycle after `q_re`.
- `q_empty`  in  1  queue empty flag.
- `out_valid`  out  1  consumer data valid.
- `out_data`  out  DATA_W  consumer data.
- `out_ready`  in  1  consumer accept.
- `grant_id`  out  $clog2(NUM_REQ)  index of the last accepted requester.
- `accept_cnt`  out  NUM_REQ*16  per-requester 16-bit saturating count of accepted writes.

## Operation
- **Write arbitration:** round-robin. The search starts at `last_grant+1` modulo NUM_REQ.
  - `last_grant` updates only on an accepted transfer.
  - Reset value of `last_grant` is NUM_REQ-1, so requester 0 wins first.
- **Write credit:** `pend` = `q_we` currently asserted (0/1).
  - `req_ready` may assert only when `q_free_entries - pend > 0`.
  - This covers the one-cycle registered write lag, so the queue never receives `we` while full.
- **Write issue:** on an accepted transfer from requester i:
  - next cycle `q_we`=1 and `q_in_data`=`req_data[i]`;
  - `grant_id`=i;
  - `accept_cnt[i]` increments, saturating at 0xFFFF.
  - At most one write is issued per cycle.
- **Read FSM:** `rd_state_t` = IDLE, FETCH, HOLD.
  - IDLE: if `!q_empty`, drive `q_re`=1 and go to FETCH.
  - FETCH: capture `q_out_data` into `out_data`, set `out_valid`=1, go to HOLD.
  - HOLD: hold `out_data` stable while `out_ready`=0.
    - On `out_ready`=1 with `!q_empty`: drive `q_re`=1 and go to FETCH; `out_valid` drops for one cycle.
    - On `out_ready`=1 with `q_empty`: go to IDLE.
- `q_re` is combinational from state and `q_empty`, and is never asserted in FETCH.
- Reads and writes proceed independently. A simultaneous `q_we` and `q_re` is legal.

## Timing
- **Reset values:** all outputs 0 (`req_ready`, `q_we`, `q_in_data`, `q_re`, `out_valid`, `out_data`, `grant_id`, `accept_cnt`); state = IDLE; `last_grant` = NUM_REQ-1.
- **Reset mid-operation:** a pending write or read is dropped. A FETCH in progress is abandoned and its data is lost.
- **Write latency:** handshake at edge N gives `q_we` high during cycle N+1.
- **Read latency:**
  - `q_re` in cycle N; `out_valid` high from edge N+2.
  - Minimum spacing between consecutive outputs is 2 cycles.
- `req_ready` is combinational from `req_valid`, `last_grant`, `q_free_entries` and `pend`.
  - A requester must hold `req_valid` and `req_data` stable until accepted.
- **Boundaries:**
  - `q_free_entries`=1 with `pend`=1: all `req_ready`=0.
  - `q_free_entries`=0: all `req_ready`=0.
  - `q_empty` in IDLE: no `q_re`.
  - A write into an empty queue becomes readable after the queue updates `q_empty`; the earliest `q_re` is the cycle after `q_we`.

## Structure
- Package `queue_ctrl_pkg` holds:
  - `rd_state_t` enum;
  - `CNT_W`=16 and `CNT_MAX` constants;
  - default `DATA_W`, `NUM_REQ`, `DEPTH`.
- Sub-module `rr_arbiter` (params `N`) has inputs `clk`, `rst`, `req[N]`, `en`, `accept`. It produces a one-hot `gnt[N]` and an encoded `gnt_id`, and holds `last_grant`.
- `queue_ctrl` contains the credit logic, write register, read FSM and counters.

## Test plan
- **Reset:** assert `rst` mid-cycle with `req_valid`=4'b1111 → all outputs 0 asynchronously. First grant after release goes to requester 0.
- **Fairness:** `req_valid`=4'b1111 held, queue drained continuously → grants follow 0,1,2,3,0. Each `accept_cnt` equals 2 after 8 accepts.
- **Full:** with no reads, requester 1 writes 0x00..0x08 → exactly 8 `q_we` pulses. `req_ready[1]` stays 0 once `q_free_entries`=1 with `pend`=1; 0x08 is not accepted.
- **Read stream:** preload 0x10,0x11,0x12 with `out_ready`=1 → `out_data` sequence 0x10,0x11,0x12, each valid one cycle apart by 2. Then FSM returns to IDLE with `q_re`=0.
- **Backpressure:** `out_ready`=0 for 5 cycles in HOLD with data 0xA5 → `out_valid`=1 and `out_data`=0xA5 stable throughout. No `q_re` is issued.
- **Simultaneous:** a write of 0x3C and a read issue in the same cycle with the queue holding 1 entry → both complete, and `q_free_entries` is unchanged afterwards.
